// File: rtl/clk_gen_multi.sv
// rtl/clk_gen_multi.sv - NCHAN programmable clock dividers with run/pause/single-step control
// Optional step_key debouncer is built when CLK_GEN_DEBOUNCE_EN is defined.
module clk_gen_multi #(
  parameter int NCHAN           = 2,
  parameter int DIV_W           = 26,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCHAN*DIV_W-1:0] div,
  input  logic [1:0]             mode,
  input  logic                   step_key,
  output logic [NCHAN-1:0]       tick,
  output logic [NCHAN-1:0]       clk_div,
  output logic [NCHAN-1:0]       busy,
  output logic                   step_ack
);

  typedef enum logic [1:0] {
    MODE_RUN   = 2'b00,
    MODE_PAUSE = 2'b01,
    MODE_STEP  = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_t;

  mode_t                  w_mode;
  logic                   w_is_run;
  logic                   w_is_step;
  logic                   w_key_level;
  logic                   w_step_req;
  logic                   w_accept;
  logic [DIV_W-1:0]       w_deff [NCHAN];
  logic [NCHAN-1:0]       w_wrap;
  logic [NCHAN-1:0]       w_half;
  logic [NCHAN-1:0]       w_active;
  logic [NCHAN-1:0]       w_advance;

  logic [DIV_W-1:0]       r_cnt    [NCHAN];
  logic [DIV_W-1:0]       r_shadow [NCHAN];
  logic [NCHAN-1:0]       r_tick;
  logic [NCHAN-1:0]       r_clk_div;
  logic [NCHAN-1:0]       r_busy;
  logic                   r_step_ack;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_key_d;

  assign w_mode    = mode_t'(mode);
  assign w_is_run  = (w_mode == MODE_RUN);
  assign w_is_step = (w_mode == MODE_STEP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], step_key};
    end
  end

`ifdef CLK_GEN_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] r_db_cnt;
  logic            r_db_level;

  // The accepted level only flips after the new level has held for DEBOUNCE_CYCLES clocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_db_cnt   <= '0;
      r_db_level <= 1'b0;
    end else if (r_sync[SYNC_STAGES-1] == r_db_level) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      r_db_cnt   <= '0;
      r_db_level <= r_sync[SYNC_STAGES-1];
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  assign w_key_level = r_db_level;
`else
  logic w_unused_db;
  assign w_unused_db = (DEBOUNCE_CYCLES > 0);
  assign w_key_level = r_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_d <= 1'b0;
    end else begin
      r_key_d <= w_key_level;
    end
  end

  assign w_step_req = w_key_level & ~r_key_d;

  always_comb begin
    for (int i = 0; i < NCHAN; i++) begin
      w_deff[i]    = (r_shadow[i] == '0) ? DIV_W'(1) : r_shadow[i];
      w_wrap[i]    = (r_cnt[i] >= w_deff[i] - DIV_W'(1));
      w_half[i]    = (r_cnt[i] >= (w_deff[i] >> 1));
      // A channel left mid-period by RUN finishes that period in STEP.
      w_active[i]  = r_busy[i] | (r_cnt[i] != '0);
      w_advance[i] = w_is_run | (w_is_step & w_active[i]);
    end
  end

  assign w_accept = w_is_step & w_step_req & ~(|w_active);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick     <= '0;
      r_clk_div  <= '0;
      r_busy     <= '0;
      r_step_ack <= 1'b0;
      for (int i = 0; i < NCHAN; i++) begin
        r_cnt[i]    <= '0;
        r_shadow[i] <= div[i*DIV_W +: DIV_W];
      end
    end else begin
      r_step_ack <= w_accept;
      for (int i = 0; i < NCHAN; i++) begin
        if (w_advance[i]) begin
          r_tick[i]    <= w_wrap[i];
          r_clk_div[i] <= w_half[i];
          if (w_wrap[i]) begin
            r_cnt[i]    <= '0;
            r_shadow[i] <= div[i*DIV_W +: DIV_W];
          end else begin
            r_cnt[i] <= r_cnt[i] + DIV_W'(1);
          end
        end else begin
          r_tick[i] <= 1'b0;
          if (w_is_step) begin
            r_clk_div[i] <= 1'b0;
          end
        end

        if (w_is_run) begin
          r_busy[i] <= 1'b0;
        end else if (w_is_step) begin
          r_busy[i] <= w_active[i] ? ~w_wrap[i] : w_accept;
        end
      end
    end
  end

  assign tick     = r_tick;
  assign clk_div  = r_clk_div;
  assign busy     = r_busy;
  assign step_ack = r_step_ack;

endmodule
